// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, ALU ops,
// state encodings and datapath select encodings.
package ctrl_pkg;

  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  // ALU operation select, also used by the ALU itself
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_SLL = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // R-type opcodes double as their ALU operation
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= ALU_XOR;
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: counts stalled cycles while a memory access is
// pending and pulses overflow when the wait limit is reached.
module ctrl_wait_cnt #(
  parameter logic [3:0] WAIT_MAX = 4'd15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic overflow
);

  logic [3:0] cnt_reg;

  // Completion in the overflow cycle wins, so ready suppresses the pulse
  assign overflow = active && !ready && (cnt_reg == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset || !active || ready || overflow) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit datapath (Moore outputs with
// MemReady/Zero gating). Define ILLEGAL_TRAP_EN to halt on illegal opcodes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'b00,
  parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemTimeout,
  output logic [3:0]  State
);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] opcode;
  logic       mem_active;
  logic       wait_overflow;
  logic       unused_instr;

  assign opcode       = Instr[15:12];
  assign unused_instr = ^Instr[11:0];
  assign State        = state_reg;
  assign mem_active   = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                        (state_reg == S_MEM_WR);

  ctrl_wait_cnt #(
    .WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .active   (mem_active),
    .ready    (MemReady),
    .overflow (wait_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    MemTimeout = wait_overflow;

    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BOFF;
        if (is_rtype(opcode)) begin
          state_next = S_EXEC_R;
        end else begin
          case (opcode)
            OP_ADDI:      state_next = S_EXEC_I;
            OP_LW, OP_SW: state_next = S_MEM_ADDR;
            OP_BEQ:       state_next = S_BRANCH;
            OP_JMP:       state_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
            default:      state_next = S_HALT;
`else
            default:      state_next = S_FETCH;
`endif
          endcase
        end
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = opcode;
        state_next = S_WB_R;
      end
      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_WB_R;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_next = S_FETCH;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = is_rtype(opcode);
        state_next = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = PC_ALUOUT;
        PCWrite    = Zero;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PC_JUMP;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset abandons any access: all strobes and selects forced idle
    if (reset) begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = RESET_PC_SEL;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ALUControl = ALU_ADD;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      MemTimeout = 1'b0;
    end
  end

endmodule
